mul_seq_ctrl: RTL and testbench
===============================

# mul_seq_ctrl

Sequencing front-end for the 16x16 unsigned pipelined `multiplier` core in the execute stage. It accepts a multiply request from the pipeline over a valid/ready handshake and converts signed operands to magnitudes. It drives and holds the core's operands and `start`, waits for `done`, then sign-corrects the 32-bit product. The result is returned as hi/lo halves with a tag on a valid/ready handshake, and a watchdog flags a core that never asserts `done`.

## Interface
- TAG_W, 3, width of the request/result tag.
- TIMEOUT, 16, maximum cycles in RUN before an error completion; must be ≥ 6.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- op_a, op_b  in  16 each  operands.
- op_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- req_tag  in  TAG_W  destination tag, returned unchanged.
- mul_a, mul_b  out  16 each  to the core's a/b.
- mul_start  out  1  to the core's start.
- mul_product  in  32  from the core's product.
- mul_done  in  1  from the core's done.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts.
- res_lo, res_hi  out  16 each  product[15:0], product[31:16].
- res_tag  out  TAG_W  tag of the request.
- res_err  out  1  watchdog fired; result forced to 0.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset output values: req_ready=1, res_valid=0, mul_start=0, busy=0, res_err=0. mul_a, mul_b, res_lo, res_hi and res_tag are all 0.
- IDLE, on req_valid & req_ready: register the operands, the tag, the signed flag and neg = op_signed & (op_a[15] ^ op_b[15]). Go to RUN.
- Operand registers hold magnitudes:
  - If op_signed and the operand is negative, store (~x + 1) truncated to 16 bits, so −32768 → 16'h8000.
  - Otherwise store x unchanged.
- RUN:
  - mul_start = 1, combinational from state.
  - mul_a and mul_b are driven from the operand registers and held stable for the whole of RUN.
  - A watchdog counter clears on entry and increments each cycle.
- In RUN with mul_done = 1:
  - Capture res = neg ? (~mul_product + 1) : mul_product, 32-bit, wrap.
  - Set res_err = 0 and go to DONE.
- In RUN with the counter reaching TIMEOUT−1 and no mul_done: res = 0, res_err = 1, go to DONE.
- If mul_done and timeout occur in the same cycle, mul_done wins and res_err = 0.
- DONE:
  - res_valid = 1 and mul_start = 0.
  - Result outputs are held until res_valid & res_ready, then go to IDLE.
  - res_ready may stay low indefinitely; no output changes while it does.
- mul_done outside RUN is ignored.
- Reset in any state forces IDLE and the reset values on the next edge. An in-flight request is dropped with no result. The core shares the same reset.

## Timing
- Handshakes:
  - Request is accepted at edge E0, when req_valid & req_ready are sampled high.
  - mul_start is high in cycles 1..5.
  - The core asserts mul_done in cycle 5, with the product valid in the same cycle.
- res_valid rises in cycle 6, so latency is 6 cycles from acceptance to res_valid.
- mul_start is low for at least 2 cycles (DONE and IDLE) between requests, so the core's internal counter always restarts from 0.
- Maximum throughput is one request per 7 cycles with res_ready tied high.
- req_ready is low from cycle 1 until the cycle after the result handshake.

## Test plan
- Unsigned 16'h1234 × 16'h5678, op_signed=0, res_ready=1 → res_valid in cycle 6. {res_hi,res_lo}=32'h0626_0060, res_err=0, tag echoed.
- Signed −3 (16'hFFFD) × 7 → {res_hi,res_lo}=32'hFFFF_FFEB. Same operands with op_signed=0 → 32'h0006_FFEB.
- Signed 16'h8000 × 16'h8000 → 32'h4000_0000. Signed 16'h8000 × 1 → 32'hFFFF_8000.
- Hold res_ready=0 for 10 cycles in DONE:
  - Outputs are stable and req_ready stays 0.
  - Raising res_ready completes the result; IDLE follows on the next cycle.
  - A second request is then accepted, and mul_start must be observed low for ≥2 cycles between runs.
- Core stub never asserts mul_done, TIMEOUT=16 → res_valid with res_err=1 and result 0 in cycle 17 after acceptance. The next normal request completes correctly.
- Assert reset in cycle 3 of RUN → next cycle: IDLE, mul_start=0, res_valid=0, req_ready=1. No result is ever produced for the dropped tag.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Sequencing front-end for the 16x16 unsigned pipelined multiplier core.
// Converts signed operands to magnitudes, sign-corrects the product, watchdogs done.
module mul_seq_ctrl #(
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  input  logic             op_signed,
  input  logic [TAG_W-1:0] req_tag,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  output logic             mul_start,
  input  logic [31:0]      mul_product,
  input  logic             mul_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_lo,
  output logic [15:0]      res_hi,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [15:0]      a_q, a_d;
  logic [15:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      res_q, res_d;
  logic             err_q, err_d;

  // Two's-complement magnitude; -32768 wraps to 16'h8000
  function automatic logic [15:0] mag16(
    input logic [15:0] x,
    input logic        s
  );
    logic [15:0] r;
    r = x;
    if (s && x[15]) r = ~x + 16'd1;
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = RUN;
          a_d     = mag16(op_a, op_signed);
          b_d     = mag16(op_b, op_signed);
          tag_d   = req_tag;
          neg_d   = op_signed & (op_a[15] ^ op_b[15]);
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (mul_done) begin
          res_d   = neg_q ? (~mul_product + 32'd1)
                          : mul_product;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mul_start = (state_q == RUN);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign res_lo    = res_q[15:0];
  assign res_hi    = res_q[31:16];
  assign res_tag   = tag_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a 5-cycle multiplier core stub.
// Vector table plus hand sequences for backpressure, timeout and reset.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] op_a, op_b;
  logic        op_signed;
  logic [2:0]  req_tag;
  logic [15:0] mul_a, mul_b;
  logic        mul_start;
  logic [31:0] mul_product;
  logic        mul_done;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_lo, res_hi;
  logic [2:0]  res_tag;
  logic        res_err;
  logic        busy;

  logic        hang;
  logic [7:0]  core_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.TAG_W(3), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_a(op_a), .op_b(op_b),
    .op_signed(op_signed), .req_tag(req_tag),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_start(mul_start),
    .mul_product(mul_product), .mul_done(mul_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_lo(res_lo), .res_hi(res_hi),
    .res_tag(res_tag), .res_err(res_err),
    .busy(busy)
  );

  // Core stub: done on the 5th consecutive start cycle
  always_ff @(posedge clk) begin
    if (reset || !mul_start) core_cnt <= 8'd0;
    else core_cnt <= core_cnt + 8'd1;
  end
  assign mul_done = mul_start && (core_cnt == 8'd4) && !hang;
  assign mul_product = {16'd0, mul_a} * {16'd0, mul_b};

  // Minimum run of low mul_start between two runs
  int gap = 0;
  int min_gap = 1000;
  bit seen_run = 1'b0;
  always @(negedge clk) begin
    if (mul_start) begin
      if (seen_run && gap > 0 && gap < min_gap) min_gap = gap;
      gap = 0;
      seen_run = 1'b1;
    end else begin
      gap = gap + 1;
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [2:0]  tag;
    logic [31:0] exp;
  } vec_t;

  // Issue one request and wait for its result; res_ready is left as set.
  task automatic run_req(input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [2:0] tag,
                         input logic [31:0] exp, input logic exp_err,
                         input int exp_lat, input string nm);
    int lat;
    bit start_ok;
    chk({nm, ".req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    op_a = a; op_b = b; op_signed = s; req_tag = tag;
    @(negedge clk);
    req_valid = 1'b0;
    op_a = 16'hDEAD; op_b = 16'hBEEF; op_signed = 1'b0;
    lat = 1;
    start_ok = 1'b1;
    while (!res_valid && lat < 40) begin
      if (!mul_start || req_ready || !busy) start_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({nm, ".run_outputs"}, 64'(start_ok), 64'd1);
    chk({nm, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, ".result"}, {32'd0, res_hi, res_lo}, {32'd0, exp});
    chk({nm, ".err"}, 64'(res_err), 64'(exp_err));
    chk({nm, ".tag"}, 64'(res_tag), 64'(tag));
    chk({nm, ".start_low"}, 64'(mul_start), 64'd0);
  endtask

  vec_t vt[8];

  initial begin
    logic [31:0] held;
    logic [2:0]  held_tag;
    bit stable;
    bit leaked;

    vt[0] = '{16'h1234, 16'h5678, 1'b0, 3'd1, 32'h0626_0060};
    vt[1] = '{16'hFFFD, 16'h0007, 1'b1, 3'd2, 32'hFFFF_FFEB};
    vt[2] = '{16'hFFFD, 16'h0007, 1'b0, 3'd3, 32'h0006_FFEB};
    vt[3] = '{16'h8000, 16'h8000, 1'b1, 3'd4, 32'h4000_0000};
    vt[4] = '{16'h8000, 16'h0001, 1'b1, 3'd5, 32'hFFFF_8000};
    vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 3'd6, 32'h0000_0001};
    vt[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 3'd7, 32'hFFFE_0001};
    vt[7] = '{16'h0005, 16'hFFFE, 1'b1, 3'd0, 32'hFFFF_FFF6};

    reset = 1'b1; req_valid = 1'b0; op_a = '0; op_b = '0;
    op_signed = 1'b0; req_tag = '0; res_ready = 1'b1; hang = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.req_ready", 64'(req_ready), 64'd1);
    chk("rst.res_valid", 64'(res_valid), 64'd0);
    chk("rst.mul_start", 64'(mul_start), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.res_err", 64'(res_err), 64'd0);
    chk("rst.data", {mul_a, mul_b, res_lo, res_hi},
        64'd0);
    chk("rst.tag", 64'(res_tag), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back vectors with res_ready tied high
    for (int i = 0; i < 8; i++) begin
      run_req(vt[i].a, vt[i].b, vt[i].s, vt[i].tag,
              vt[i].exp, 1'b0, 6, $sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d.idle", i), 64'(req_ready), 64'd1);
    end

    // Backpressure: hold res_ready low 10 cycles in DONE
    res_ready = 1'b0;
    run_req(16'h0102, 16'h0304, 1'b0, 3'd5,
            32'h0003_0A08, 1'b0, 6, "bp");
    held = {res_hi, res_lo};
    held_tag = res_tag;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!res_valid || req_ready || mul_start ||
          {res_hi, res_lo} !== held || res_tag !== held_tag ||
          res_err !== 1'b0 || !busy)
        stable = 1'b0;
    end
    chk("bp.stable", 64'(stable), 64'd1);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp.idle", {62'd0, req_ready, res_valid}, 64'd2);
    chk("bp.busy", 64'(busy), 64'd0);
    run_req(16'h0010, 16'h0010, 1'b0, 3'd6,
            32'h0000_0100, 1'b0, 6, "bp2");
    @(negedge clk);

    // Watchdog: core never asserts done
    hang = 1'b1;
    run_req(16'h0003, 16'h0004, 1'b0, 3'd2,
            32'h0, 1'b1, 17, "tmo");
    hang = 1'b0;
    @(negedge clk);
    run_req(16'hFFFF, 16'h0002, 1'b1, 3'd3,
            32'hFFFF_FFFE, 1'b0, 6, "post_tmo");
    @(negedge clk);

    // Reset in cycle 3 of RUN drops the request
    req_valid = 1'b1;
    op_a = 16'h0007; op_b = 16'h0009; op_signed = 1'b0;
    req_tag = 3'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstrun.in_run", 64'(mul_start), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstrun.idle",
        {60'd0, req_ready, mul_start, res_valid, busy},
        64'd8);
    leaked = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid || mul_start) leaked = 1'b1;
    end
    chk("rstrun.no_result", 64'(leaked), 64'd0);
    run_req(16'h0100, 16'hFF00, 1'b1, 3'd1,
            32'hFFFF_0000, 1'b0, 6, "post_rst");
    @(negedge clk);

    chk("start_gap_min2", 64'(min_gap >= 2), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
